// File: rtl/bt_uart_fifo_if.sv
// Byte/serial bundle for bt_uart_fifo: module pins plus the CPU-side FIFO port.
// slave = the UART itself, master = the bus/pin side that talks to it.
// The same widths must be used for the interface and the UART instance.
interface bt_uart_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 tx;
  logic [DATA_BITS-1:0] din;
  logic                 enable;
  logic                 tx_full;
  logic                 busy;
  logic                 done;
  logic [DATA_BITS-1:0] dout;
  logic                 rd;
  logic                 avail;
  logic                 overrun;
  logic                 frame_err;
  logic                 parity_err;

  modport slave (
    input  rx, din, enable, rd,
    output tx, tx_full, busy, done, dout, avail, overrun, frame_err, parity_err
  );

  modport master (
    output rx, din, enable, rd,
    input  tx, tx_full, busy, done, dout, avail, overrun, frame_err, parity_err
  );
endinterface

// File: rtl/bt_uart_fifo.sv
// UART with built-in baud divider, optional parity and first-word-fall-through TX/RX FIFOs.
// Latency: enable to start bit 2 cycles; stop-bit sample to avail 1 cycle.
// Backpressure: pushes are dropped while tx_full; received frames are dropped (overrun) while the RX FIFO is full.
module bt_uart_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input logic          clk_in,
  input logic          reset,
  bt_uart_fifo_if.slave bus
);
  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int BW   = $clog2(DATA_BITS);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // Two FIFO lanes sharing one implementation: lane 0 = TX, lane 1 = RX.
  logic [1:0]           f_push, f_pop, f_full, f_empty;
  logic [DATA_BITS-1:0] f_wdat [2];
  logic [DATA_BITS-1:0] f_head [2];

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wptr, rptr;
    logic                 do_push, do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
    assign f_empty[g] = (wptr == rptr);
    assign f_full[g]  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push    = f_push[g] && !f_full[g];
    assign do_pop     = f_pop[g] && !f_empty[g];
    assign f_head[g]  = f_empty[g] ? '0 : mem[rptr[AW-1:0]];

    // Storage write; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_in) begin
      if (do_push) mem[wptr[AW-1:0]] <= f_wdat[g];
    end

    // Pointer advance, wrapping modulo 2*FIFO_DEPTH.
    always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (do_push) wptr <= wptr + 1'b1;
        if (do_pop)  rptr <= rptr + 1'b1;
      end
    end
  end

  // ---------------- transmitter ----------------
  logic [2:0]           tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par, tx_q, done_q, tx_tick, tx_pop;

  assign tx_tick = (tx_cnt == CNT_LAST);
  // Pop from IDLE, or at the end of STOP so back-to-back frames have no gap.
  assign tx_pop  = !f_empty[0] && ((tx_state == S_IDLE) || ((tx_state == S_STOP) && tx_tick));

  assign f_push[0] = bus.enable;
  assign f_wdat[0] = bus.din;
  assign f_pop[0]  = tx_pop;

  assign bus.tx      = tx_q;
  assign bus.done    = done_q;
  assign bus.tx_full = f_full[0];
  assign bus.busy    = !f_empty[0] || (tx_state != S_IDLE);

  // TX FSM: every non-idle state lasts DIV cycles; tx is registered and resets high.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((tx_state == S_IDLE) || tx_tick) tx_cnt <= '0;
      else                                 tx_cnt <= tx_cnt + 1'b1;
      if (tx_pop) begin
        tx_sh    <= f_head[0];
        tx_par   <= (^f_head[0]) ^ (PARITY == 1);
        tx_q     <= 1'b0;
        tx_state <= S_START;
      end
      if (tx_tick) begin
        case (tx_state)
          S_START: begin
            tx_q     <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
            tx_bit   <= '0;
            tx_state <= S_DATA;
          end
          S_DATA: begin
            if (tx_bit == BIT_LAST) begin
              tx_q     <= (PARITY != 0) ? tx_par : 1'b1;
              tx_state <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              tx_q   <= tx_sh[0];
              tx_sh  <= tx_sh >> 1;
              tx_bit <= tx_bit + 1'b1;
            end
          end
          S_PAR: begin
            tx_q     <= 1'b1;
            tx_state <= S_STOP;
          end
          S_STOP: begin
            done_q <= 1'b1;
            if (f_empty[0]) tx_state <= S_IDLE;
          end
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------- receiver ----------------
  logic                 rx_s1, rx_s2, rx_arm, rx_pbit;
  logic [2:0]           rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 stop_smp, set_ovr, set_fe, set_pe;
  logic                 ovr_q, fe_q, pe_q;

  assign stop_smp = (rx_state == S_STOP) && (rx_cnt == CNT_LAST);
  assign set_ovr  = stop_smp && f_full[1];
  assign set_fe   = stop_smp && !rx_s2;
  assign set_pe   = stop_smp && (PARITY != 0) && (((^rx_sh) ^ rx_pbit) != (PARITY == 1));

  assign f_push[1] = stop_smp && !f_full[1];
  assign f_wdat[1] = rx_sh;
  assign f_pop[1]  = bus.rd;

  assign bus.avail      = !f_empty[1];
  assign bus.dout       = f_head[1];
  assign bus.overrun    = ovr_q;
  assign bus.frame_err  = fe_q;
  assign bus.parity_err = pe_q;

  // Two-flop synchronizer for the asynchronous rx pin (idle high).
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= bus.rx;
      rx_s2 <= rx_s1;
    end
  end

  // RX FSM: half-bit wait validates the start bit, then one sample per DIV cycles.
  // rx_arm requires the line to be seen high before a falling edge counts.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_pbit  <= 1'b0;
      rx_arm   <= 1'b0;
    end else begin
      rx_cnt <= rx_cnt + 1'b1;
      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          if (rx_s2) rx_arm <= 1'b1;
          else if (rx_arm) begin
            rx_arm   <= 1'b0;
            rx_state <= S_START;
          end
        end
        S_START: if (rx_cnt == CNT_HALF) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_cnt == CNT_LAST) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
          rx_bit <= rx_bit + 1'b1;
          if (rx_bit == BIT_LAST) rx_state <= (PARITY != 0) ? S_PAR : S_STOP;
        end
        S_PAR: if (rx_cnt == CNT_LAST) begin
          rx_cnt   <= '0;
          rx_pbit  <= rx_s2;
          rx_state <= S_STOP;
        end
        S_STOP: if (rx_cnt == CNT_LAST) begin
          rx_cnt   <= '0;
          rx_state <= S_IDLE;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags: a new error beats a simultaneous rd clear.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      ovr_q <= 1'b0;
      fe_q  <= 1'b0;
      pe_q  <= 1'b0;
    end else begin
      if (set_ovr)     ovr_q <= 1'b1;
      else if (bus.rd) ovr_q <= 1'b0;
      if (set_fe)      fe_q  <= 1'b1;
      else if (bus.rd) fe_q  <= 1'b0;
      if (set_pe)      pe_q  <= 1'b1;
      else if (bus.rd) pe_q  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bt_uart_fifo.sv
// Bench for bt_uart_fifo: two instances (8N1 depth 4, and 7E1 depth 4), both DIV=10.
// A frame-level model predicts tx/busy/done/tx_full of instance A every cycle.
// Directed vectors cover loopback, overrun, glitch, framing/parity errors and reset abort.
`timescale 1ns/1ps
module tb_bt_uart_fifo;
  localparam int DIV     = 10;
  localparam int FRAME_A = 10 * DIV;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  bt_uart_fifo_if #(.DATA_BITS(8)) a_if ();
  bt_uart_fifo_if #(.DATA_BITS(7)) b_if ();

  logic loop_a  = 1'b0;
  logic rxa_drv = 1'b1;
  logic rxb_drv = 1'b1;
  assign a_if.rx = loop_a ? a_if.tx : rxa_drv;
  assign b_if.rx = rxb_drv;

  bt_uart_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4))
    dut_a (.clk_in(clk_in), .reset(rst_n), .bus(a_if));
  bt_uart_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(4))
    dut_b (.clk_in(clk_in), .reset(rst_n), .bus(b_if));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---- frame-level model of the A transmitter ----
  logic [7:0] mq[$];
  int         cyc      = 0;
  bit         f_act    = 0;
  int         f_start  = 0;
  logic [7:0] f_byte   = 8'h00;
  int         done_cyc = -1;
  bit         full_b;
  bit         cmp_en   = 0;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      f_act    = 0;
      done_cyc = -1;
    end else begin
      cyc    = cyc + 1;
      full_b = (mq.size() == 4);
      if (f_act && cyc >= f_start + FRAME_A) begin
        f_act    = 0;
        done_cyc = cyc;
      end
      if (!f_act && mq.size() != 0) begin
        f_byte  = mq.pop_front();
        f_start = cyc;
        f_act   = 1;
      end
      if (a_if.enable && !full_b) mq.push_back(a_if.din);
    end
  end

  always @(negedge clk_in) begin
    if (rst_n && cmp_en) begin
      int   k;
      logic e_tx;
      e_tx = 1'b1;
      if (f_act) begin
        k = (cyc - f_start) / DIV;
        if (k == 0)      e_tx = 1'b0;
        else if (k <= 8) e_tx = f_byte[k-1];
      end
      chk("a_tx",   a_if.tx,      e_tx);
      chk("a_busy", a_if.busy,    f_act || (mq.size() != 0));
      chk("a_done", a_if.done,    cyc == done_cyc);
      chk("a_full", a_if.tx_full, mq.size() == 4);
    end
  end

  // ---- stimulus helpers ----
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  task automatic push_a(input logic [7:0] d);
    a_if.din = d; a_if.enable = 1'b1;
    @(negedge clk_in);
    a_if.enable = 1'b0;
  endtask

  task automatic push_b(input logic [6:0] d);
    b_if.din = d; b_if.enable = 1'b1;
    @(negedge clk_in);
    b_if.enable = 1'b0;
  endtask

  task automatic read_a(input string nm, input logic [7:0] e);
    chk({nm, "_avail"}, a_if.avail, 1);
    chk(nm, a_if.dout, e);
    a_if.rd = 1'b1;
    @(negedge clk_in);
    a_if.rd = 1'b0;
  endtask

  task automatic rd_b();
    b_if.rd = 1'b1;
    @(negedge clk_in);
    b_if.rd = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    while (a_if.busy && n < budget) begin @(negedge clk_in); n++; end
    chk("a_idle_wait", a_if.busy, 0);
  endtask

  task automatic wait_avail_a(input int budget);
    int n = 0;
    while (!a_if.avail && n < budget) begin @(negedge clk_in); n++; end
    chk("a_avail_wait", a_if.avail, 1);
  endtask

  task automatic wait_avail_b(input int budget);
    int n = 0;
    while (!b_if.avail && n < budget) begin @(negedge clk_in); n++; end
    chk("b_avail_wait", b_if.avail, 1);
  endtask

  // bits[0] goes on the wire first, each held DIV cycles
  task automatic drive_a(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin rxa_drv = bits[i]; repeat (DIV) @(negedge clk_in); end
    rxa_drv = 1'b1;
  endtask

  task automatic drive_b(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin rxb_drv = bits[i]; repeat (DIV) @(negedge clk_in); end
    rxb_drv = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    a_if.din = '0; a_if.enable = 1'b0; a_if.rd = 1'b0;
    b_if.din = '0; b_if.enable = 1'b0; b_if.rd = 1'b0;
    repeat (3) @(negedge clk_in);

    // reset values
    chk("rst_tx",    a_if.tx, 1);
    chk("rst_busy",  a_if.busy, 0);
    chk("rst_done",  a_if.done, 0);
    chk("rst_full",  a_if.tx_full, 0);
    chk("rst_avail", a_if.avail, 0);
    chk("rst_dout",  a_if.dout, 0);
    chk("rst_ovr",   a_if.overrun, 0);
    chk("rst_fe",    a_if.frame_err, 0);
    chk("rst_pe",    a_if.parity_err, 0);
    rst_n  = 1'b1;
    cmp_en = 1;
    repeat (2) @(negedge clk_in);

    // single 0x55 frame, hand-timed
    t0 = cyc;
    push_a(8'h55);
    chk("t1_busy_c1", a_if.busy, 1);
    chk("t1_tx_c1",   a_if.tx, 1);
    wait_to(t0 + 2);   chk("t1_tx_c2", a_if.tx, 0);
    wait_to(t0 + 11);  chk("t1_tx_c11", a_if.tx, 0);
    wait_to(t0 + 12);  chk("t1_tx_c12", a_if.tx, 1);
    wait_to(t0 + 22);  chk("t1_tx_c22", a_if.tx, 0);
    wait_to(t0 + 101); chk("t1_tx_c101", a_if.tx, 1);
    chk("t1_done_c101", a_if.done, 0);
    chk("t1_busy_c101", a_if.busy, 1);
    wait_to(t0 + 102); chk("t1_done_c102", a_if.done, 1);
    chk("t1_busy_c102", a_if.busy, 0);
    wait_to(t0 + 103); chk("t1_done_c103", a_if.done, 0);

    // loopback, three back-to-back frames
    loop_a = 1'b1;
    push_a(8'h00); push_a(8'hFF); push_a(8'hA5);
    wait_idle_a(2000);
    repeat (5) @(negedge clk_in);
    read_a("lb0", 8'h00);
    read_a("lb1", 8'hFF);
    read_a("lb2", 8'hA5);
    chk("lb_empty", a_if.avail, 0);
    chk("lb_fe", a_if.frame_err, 0);
    chk("lb_ovr", a_if.overrun, 0);

    // TX full / RX overrun: one byte in flight, four queued, sixth dropped
    push_a(8'h11); push_a(8'h12); push_a(8'h13); push_a(8'h14); push_a(8'h15);
    chk("ov_txfull", a_if.tx_full, 1);
    push_a(8'h16);
    wait_idle_a(2000);
    repeat (5) @(negedge clk_in);
    chk("ov_flag", a_if.overrun, 1);
    read_a("ov0", 8'h11);
    chk("ov_clr", a_if.overrun, 0);
    read_a("ov1", 8'h12);
    read_a("ov2", 8'h13);
    read_a("ov3", 8'h14);
    chk("ov_empty", a_if.avail, 0);

    // glitch shorter than half a bit
    loop_a = 1'b0;
    rxa_drv = 1'b0;
    repeat (3) @(negedge clk_in);
    rxa_drv = 1'b1;
    repeat (150) @(negedge clk_in);
    chk("gl_avail", a_if.avail, 0);
    chk("gl_fe", a_if.frame_err, 0);
    chk("gl_ovr", a_if.overrun, 0);

    // good manual frame 0xC3, then 0x3C with low stop bit
    drive_a({1'b1, 8'hC3, 1'b0}, 10);
    wait_avail_a(50);
    chk("rx_fe0", a_if.frame_err, 0);
    read_a("rx_c3", 8'hC3);
    repeat (5) @(negedge clk_in);
    drive_a({1'b0, 8'h3C, 1'b0}, 10);
    wait_avail_a(50);
    chk("fe_set", a_if.frame_err, 1);
    read_a("fe_byte", 8'h3C);
    chk("fe_clr", a_if.frame_err, 0);
    chk("fe_empty", a_if.avail, 0);

    // B: 7E1 receive with wrong then right parity
    drive_b({1'b1, 1'b1, 7'h41, 1'b0}, 10);
    wait_avail_b(50);
    chk("pe_byte", b_if.dout, 7'h41);
    chk("pe_set", b_if.parity_err, 1);
    chk("pe_fe", b_if.frame_err, 0);
    rd_b();
    chk("pe_clr", b_if.parity_err, 0);
    drive_b({1'b1, 1'b1, 7'h43, 1'b0}, 10);
    wait_avail_b(50);
    chk("pok_byte", b_if.dout, 7'h43);
    chk("pok_pe", b_if.parity_err, 0);
    rd_b();

    // B: transmitted even parity bit of 0x41 is 0
    t0 = cyc;
    push_b(7'h41);
    wait_to(t0 + 2 + 75); chk("btx_d6", b_if.tx, 1);
    wait_to(t0 + 2 + 85); chk("btx_par", b_if.tx, 0);
    wait_to(t0 + 2 + 95); chk("btx_stop", b_if.tx, 1);
    wait_to(t0 + 102);    chk("btx_done", b_if.done, 1);

    // reset mid-transmit aborts everything
    loop_a = 1'b1;
    repeat (3) @(negedge clk_in);
    t0 = cyc;
    push_a(8'h5A);
    push_a(8'h77);
    wait_to(t0 + 32);
    chk("ra_tx_pre", a_if.tx, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_tx", a_if.tx, 1);
    chk("ra_busy", a_if.busy, 0);
    chk("ra_full", a_if.tx_full, 0);
    chk("ra_avail", a_if.avail, 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    push_a(8'h69);
    wait_idle_a(2000);
    repeat (5) @(negedge clk_in);
    read_a("ra_new", 8'h69);
    chk("ra_empty", a_if.avail, 0);
    chk("ra_fe", a_if.frame_err, 0);
    chk("ra_ovr", a_if.overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bt_uart_fifo.md
# bt_uart_fifo

Parametrised UART for the Bluetooth module link. It adds a compile-time baud divisor, data width, optional parity, and RX/TX FIFOs so the CPU can queue bytes instead of handshaking each one. It connects directly to the Bluetooth module's rx/tx pins and presents a FIFO-style byte interface to the peripheral bus. It also contains its own baud generation, so no external frequency divider is needed.

## Interface
- CLK_HZ, 50000000: clk_in frequency in Hz.
- BAUD, 9600: line rate. DIV = CLK_HZ/BAUD (integer division), clk_in cycles per bit, must be ≥ 4.
- DATA_BITS, 8: payload bits per frame, 5..8.
- PARITY, 0: 0 none, 1 odd, 2 even.
- FIFO_DEPTH, 16: entries per FIFO, power of 2, ≥ 2.
- clk_in  in  1  system clock; everything is synchronous to its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  serial input from the module, idle high, asynchronous to clk_in.
- tx  out  1  serial output to the module, idle high.
- din  in  DATA_BITS  byte to transmit.
- enable  in  1  push din into the TX FIFO; ignored when tx_full.
- tx_full  out  1  TX FIFO full.
- busy  out  1  TX FIFO not empty or a frame is on the wire.
- done  out  1  one-cycle pulse at the end of each transmitted stop bit.
- dout  out  DATA_BITS  RX FIFO head (first-word fall-through).
- rd  in  1  pop the RX FIFO head; ignored when !avail.
- avail  out  1  RX FIFO not empty.
- overrun  out  1  sticky flag: a frame was received while the RX FIFO was full. Cleared by a cycle with rd=1.
- frame_err  out  1  sticky flag: a stop bit was sampled low. Cleared by rd.
- parity_err  out  1  sticky flag: a parity mismatch occurred. Cleared by rd. Stays 0 when PARITY=0.

## Operation
- Frame format: start bit (0), DATA_BITS data bits LSB first, parity bit (if PARITY≠0), one stop bit (1).
- TX FSM states: IDLE → START → DATA → PARITY (skipped when PARITY=0) → STOP → IDLE.
  - In IDLE with the FIFO non-empty, pop the FIFO head into the shifter and enter START on the same cycle.
  - Each state holds for exactly DIV cycles.
  - Leaving STOP pulses done. If the FIFO is non-empty at that point, go directly to START with no idle gap.
- RX path:
  - rx passes through a 2-FF synchronizer.
  - RX FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
  - A falling edge in IDLE starts a DIV/2 wait. If the line is high at that sample, the start bit is treated as a glitch and the FSM returns to IDLE.
  - All later samples are taken every DIV cycles, so each lands mid-bit.
  - At the STOP sample, the byte is written to the RX FIFO even on a frame or parity error. The error flags are set alongside the write.
  - If the RX FIFO is full, the byte is dropped and overrun is set.
  - After STOP the FSM returns to IDLE and waits for rx high before arming a new start detect.
- FIFOs use pointers one bit wider than log2(FIFO_DEPTH).
  - full and empty are decided by comparing the extra MSB.
  - Pointers wrap modulo 2×FIFO_DEPTH.
  - Simultaneous push and pop on a full or empty FIFO: a pop on empty is ignored and a push on full is ignored. Otherwise both happen and the count is unchanged.
- Error flags: if a flag set and rd occur in the same cycle, set wins.

## Timing
- Reset values: tx=1, busy=0, done=0, tx_full=0, avail=0, dout=0, overrun=0, frame_err=0, parity_err=0. Both FIFOs are emptied and both FSMs go to IDLE.
- Reset asserted mid-frame aborts the frame. tx returns to 1 asynchronously.
- enable to tx falling edge (start bit): 2 cycles when idle (FIFO write, then FSM pop).
- Frame length: (2 + DATA_BITS + (PARITY≠0)) × DIV cycles.
- busy rises the cycle after an accepted enable and falls in the same cycle done pulses with the FIFO empty.
- avail rises 1 cycle after the stop-bit sample; dout is valid in that same cycle.
- After rd, the next entry (or avail=0) appears on the following cycle.
- tx_full reflects a push on the cycle after that push.

## Test plan
- CLK_HZ=1000000, BAUD=100000 (DIV=10), PARITY=0: enable with din=0x55 → tx low for cycles 2–11, then bits 1,0,1,0,1,0,1,0, stop high, done at cycle 102, busy low the same cycle.
- Loop tx back to rx; push 0x00, 0xFF, 0xA5 back-to-back → contiguous frames with no idle gap; avail rises; three rd cycles return 0x00, 0xFF, 0xA5 in order; no error flags set.
- PARITY=2, DATA_BITS=7: drive 0x41 with a wrong parity bit → byte 0x41 in the FIFO and parity_err=1; rd clears the flag.
- FIFO_DEPTH=4: push 5 bytes with no transmit progress → tx_full after the 4th push, 5th push ignored, exactly 4 frames sent. Receive 5 frames with no rd → overrun=1 and the first 4 bytes intact.
- Glitch: rx low for 3 cycles (< DIV/2) → no byte and no flags. Stop bit driven low → frame_err=1.
- Assert reset for 1 cycle mid-transmit → tx=1 immediately, busy=0, FIFOs empty; a new enable afterwards sends a clean frame.
